qspi_psram_model: RTL and testbench
===================================

Name: qspi_psram_model

Overview:
- Clock-oversampled, parametrised serial PSRAM device model used as the external memory target in SoC-level benches.
- Extends the earlier quad-only model with:
  - SPI, quad-I/O and QPI command modes.
  - Configurable dummy cycles, memory depth and page-wrap size.
  - Explicit output-enable.
  - Reset-enable/reset command pair.
- All logic runs on one system clock; sck and ce_n are sampled, not used as clocks.
- Sits beside the QSPI controller, attached to its pad-level dio/sck/ce_n nets.

Parameters:
- MEM_BYTES, 512, storage depth in bytes; byte address = addr mod MEM_BYTES.
- PAGE_BYTES, 1024, burst wrap boundary; must be a power of two.
- QUAD_DUMMY, 6, dummy sck cycles for 0xEB in quad and QPI modes.
- FAST_DUMMY, 8, dummy sck cycles for 0x0B in SPI mode.
- ADDR_BITS, 24, address length in bits.

Ports:
- clk, in, 1, system clock; must be at least 4x sck frequency.
- rst_n, in, 1, asynchronous active-low reset.
- sck, in, 1, serial clock from the controller.
- ce_n, in, 1, chip enable, active low.
- dio_in, in, 4, sampled data lines.
- dio_out, out, 4, driven data.
- dio_oe, out, 4, per-line output enable.
- qpi_mode, out, 1, high while QPI mode is active.
- cmd_err, out, 1, one-clk pulse when an unsupported command is seen.

Behaviour:
- Reset: state IDLE, dio_oe=0, dio_out=0, qpi_mode=0, cmd_err=0. Memory contents are not cleared.
- Edge detection:
  - sck, ce_n and dio_in pass through a 2-flop sync plus a previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - All actions below occur in the clk cycle after the detected edge.
- ce_n fall: enter CMD, bit counter = 0.
- ce_n rise (any state): go to IDLE, dio_oe=0. A partially shifted write byte is discarded; completed bytes are already stored.
- sck edges while ce_n is high are ignored.
- CMD state:
  - SPI: 8 rising edges capture dio_in[0] MSB-first.
  - QPI: 2 rising edges capture nibbles.
- Command decode:
  - 03: SPI read, 0 dummy.
  - 0B: SPI fast read, FAST_DUMMY cycles.
  - EB: quad read, QUAD_DUMMY cycles.
  - 02: SPI write.
  - 38: quad write.
  - 35: enter QPI (SPI mode only). qpi_mode is set at ce_n rise.
  - F5: exit QPI (QPI mode only). qpi_mode is cleared at ce_n rise.
  - 66: reset enable. Sets the rst_en flag; any other command clears it.
  - 99: when rst_en is set, clears qpi_mode at ce_n rise.
  - Any other code: cmd_err pulse, state IGNORE until ce_n rise.
- Width rules:
  - 03/0B/02 use 1-bit address/data in SPI mode.
  - EB/38 use 4-bit address/data.
  - In QPI all phases are 4-bit.
- ADDR state: ADDR_BITS/width rising edges, MSB-first.
- DUMMY state: counts the configured cycles. Zero dummy goes straight to RD.
- RD state:
  - Byte fetched from mem[addr] at the last address/dummy rise, then at every byte boundary.
  - Output is updated on the sck fall after the fetch; the next bit or nibble is shifted on each subsequent fall.
  - Lines driven: dio_out[1] with dio_oe=4'b0010 (1-bit), or [3:0] with 4'b1111 (4-bit).
- WR state: bits shifted on rise; each completed byte is written on the same rise that completes it, then addr advances.
- Address advance: addr = {addr high bits, (addr+1) low log2(PAGE_BYTES) bits}, i.e. wrap within the page.
- Simultaneous ce_n rise and sck rise in the same clk: ce_n wins, no capture.

Decomposition:
- Package qspi_psram_pkg:
  - State enum: IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE.
  - Command code constants.
  - Function next_addr(addr, PAGE_BYTES).
- Sub-module qspi_edge_sync: synchronisers plus rise/fall pulse generation for sck and ce_n, shared with other pad-level models.

Test Plan:
- Quad write, then quad read:
  - 38, addr 0x000010, bytes A5 3C, ce_n high.
  - EB, addr 0x000010, 6 dummy.
  - Expect dio nibbles A,5,3,C; dio_oe=4'hF only during RD.
- SPI path:
  - 02 to addr 0x20 with byte 0x81.
  - 03 from addr 0x20: dio[1] serial 1000_0001, dio_oe=4'b0010.
  - 0B from addr 0x20: same data after 8 dummy cycles.
- QPI mode:
  - 35 in SPI: qpi_mode=1 after ce_n rise.
  - EB with 2-cycle command returns stored data.
  - F5: qpi_mode=0.
  - 66 then 99 while in QPI also returns qpi_mode to 0.
- Page wrap: with PAGE_BYTES=4, quad write 4 bytes starting at addr 0x02 stores them at 2,3,0,1; readback matches.
- Aborts and errors:
  - ce_n rises after 1 nibble of the second write byte: only the first byte is stored.
  - Command 0x5A: cmd_err is a one-clk pulse, no dio_oe until the next ce_n fall.
- Async reset: rst_n low mid-RD drops dio_oe=0 and qpi_mode=0 immediately; memory contents survive a subsequent read.

Source files
------------

// File: rtl/qspi_psram_pkg.sv
// rtl/qspi_psram_pkg.sv - shared types, command codes and address helper for the PSRAM model
//
// Contents:
//   state_t   : device state machine encoding
//   CMD_*     : supported command opcodes
//   next_addr : increment an address, wrapping inside a power-of-two page
package qspi_psram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_FAST_READ  = 8'h0B;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE      = 8'h02;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
  localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI   = 8'hF5;
  localparam logic [7:0] CMD_RST_EN     = 8'h66;
  localparam logic [7:0] CMD_RST        = 8'h99;

  // High bits are kept; only the in-page offset increments, so bursts wrap at the page edge.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input int unsigned page_bytes);
    logic [31:0] mask;
    mask = page_bytes - 1;
    return (addr & ~mask) | ((addr + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// rtl/qspi_edge_sync.sv - two-flop synchroniser with registered rise/fall pulse outputs
//
// Ports:
//   i_clk   : sampling clock
//   i_rst_n : asynchronous active-low reset (all stages load RST_VAL)
//   i_sig   : asynchronous input lines
//   o_rise  : one-clk pulse per line on a synchronised 0->1 transition
//   o_fall  : one-clk pulse per line on a synchronised 1->0 transition
module qspi_edge_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_sig,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_sig;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/qspi_psram_model.sv
// rtl/qspi_psram_model.sv - clock-oversampled SPI/quad/QPI serial PSRAM device model
//
// Ports:
//   i_clk      : system clock, at least 4x sck
//   i_rst_n    : asynchronous active-low reset (memory array is not cleared)
//   i_sck      : serial clock from the controller (sampled)
//   i_ce_n     : chip enable, active low (sampled)
//   i_dio_in   : pad data lines as seen by the device
//   o_dio_out  : data driven by the device
//   o_dio_oe   : per-line output enable
//   o_qpi_mode : high while QPI mode is active
//   o_cmd_err  : one-clk pulse on an unsupported command
module qspi_psram_model
  import qspi_psram_pkg::*;
#(
  parameter int MEM_BYTES  = 512,
  parameter int PAGE_BYTES = 1024,
  parameter int QUAD_DUMMY = 6,
  parameter int FAST_DUMMY = 8,
  parameter int ADDR_BITS  = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sck,
  input  logic       i_ce_n,
  input  logic [3:0] i_dio_in,
  output logic [3:0] o_dio_out,
  output logic [3:0] o_dio_oe,
  output logic       o_qpi_mode,
  output logic       o_cmd_err
);

  localparam int         MEM_AW      = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [7:0] ADDR_LAST_Q = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] ADDR_LAST_S = 8'(ADDR_BITS - 1);

  logic [1:0]           w_rise, w_fall;
  logic                 w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
  logic [3:0]           r_dio_meta, r_dio_sync;
  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [7:0]           r_sr;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_dummy_n;
  logic                 r_wide, r_is_rd, r_qpi, r_rst_en, r_qpi_set, r_qpi_clr;
  logic [3:0]           r_dio_out, r_dio_oe;
  logic                 r_cmd_err;
  logic [7:0]           r_mem [MEM_BYTES];
  logic [7:0]           w_shift;
  logic                 w_unit_last, w_addr_last, w_mem_we;
  logic [ADDR_BITS-1:0] w_addr_shift, w_addr_next;

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_BITS-1:0] a);
    return MEM_AW'(32'(a) % 32'(MEM_BYTES));
  endfunction

  // ce_n resets high so releasing reset with the bus idle produces no spurious fall.
  qspi_edge_sync #(.W(2), .RST_VAL(2'b10)) u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   ({i_ce_n, i_sck}),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_sck_rise = w_rise[0];
  assign w_sck_fall = w_fall[0];
  assign w_ce_rise  = w_rise[1];
  assign w_ce_fall  = w_fall[1];

  // Data lines take the same two-flop path as sck so they line up with the detected edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dio_meta <= '0;
      r_dio_sync <= '0;
    end else begin
      r_dio_meta <= i_dio_in;
      r_dio_sync <= r_dio_meta;
    end
  end

  assign w_shift      = r_wide ? {r_sr[3:0], r_dio_sync} : {r_sr[6:0], r_dio_sync[0]};
  assign w_unit_last  = r_wide ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
  assign w_addr_shift = r_wide ? {r_addr[ADDR_BITS-5:0], r_dio_sync}
                               : {r_addr[ADDR_BITS-2:0], r_dio_sync[0]};
  assign w_addr_last  = (r_cnt == (r_wide ? ADDR_LAST_Q : ADDR_LAST_S));
  assign w_addr_next  = ADDR_BITS'(next_addr(32'(r_addr), PAGE_BYTES));

  // ce_n rise in the same clk as the completing sck rise suppresses the write.
  assign w_mem_we = (r_state == WR) && w_sck_rise && !w_ce_rise && !w_ce_fall && w_unit_last;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[mem_idx(r_addr)] <= w_shift;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_addr    <= '0;
      r_dummy_n <= '0;
      r_wide    <= 1'b0;
      r_is_rd   <= 1'b0;
      r_qpi     <= 1'b0;
      r_rst_en  <= 1'b0;
      r_qpi_set <= 1'b0;
      r_qpi_clr <= 1'b0;
      r_dio_out <= '0;
      r_dio_oe  <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_ce_rise) begin
        // Mode changes requested during the transaction take effect on deselect.
        r_state   <= IDLE;
        r_dio_oe  <= '0;
        r_qpi_set <= 1'b0;
        r_qpi_clr <= 1'b0;
        if (r_qpi_set)      r_qpi <= 1'b1;
        else if (r_qpi_clr) r_qpi <= 1'b0;
      end else if (w_ce_fall) begin
        r_state  <= CMD;
        r_cnt    <= '0;
        r_sr     <= '0;
        r_wide   <= r_qpi;
        r_dio_oe <= '0;
      end else begin
        case (r_state)
          CMD: if (w_sck_rise) begin
            r_sr  <= w_shift;
            r_cnt <= r_cnt + 8'd1;
            if (w_unit_last) begin
              r_cnt     <= '0;
              r_rst_en  <= (w_shift == CMD_RST_EN);
              r_dummy_n <= '0;
              r_state   <= IGNORE;
              case (w_shift)
                CMD_READ:       begin r_state <= ADDR; r_is_rd <= 1'b1; end
                CMD_FAST_READ:  begin r_state <= ADDR; r_is_rd <= 1'b1; r_dummy_n <= 8'(FAST_DUMMY); end
                CMD_QUAD_READ:  begin r_state <= ADDR; r_is_rd <= 1'b1; r_wide <= 1'b1; r_dummy_n <= 8'(QUAD_DUMMY); end
                CMD_WRITE:      begin r_state <= ADDR; r_is_rd <= 1'b0; end
                CMD_QUAD_WRITE: begin r_state <= ADDR; r_is_rd <= 1'b0; r_wide <= 1'b1; end
                CMD_ENTER_QPI:  if (!r_qpi) r_qpi_set <= 1'b1; else r_cmd_err <= 1'b1;
                CMD_EXIT_QPI:   if (r_qpi) r_qpi_clr <= 1'b1; else r_cmd_err <= 1'b1;
                CMD_RST_EN:     ;
                CMD_RST:        if (r_rst_en) r_qpi_clr <= 1'b1;
                default:        r_cmd_err <= 1'b1;
              endcase
            end
          end
          ADDR: if (w_sck_rise) begin
            r_addr <= w_addr_shift;
            r_cnt  <= r_cnt + 8'd1;
            if (w_addr_last) begin
              r_cnt <= '0;
              if (!r_is_rd) begin
                r_state <= WR;
              end else if (r_dummy_n == 8'd0) begin
                r_state <= RD;
                r_sr    <= r_mem[mem_idx(w_addr_shift)];
              end else begin
                r_state <= DUMMY;
              end
            end
          end
          DUMMY: if (w_sck_rise) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == r_dummy_n - 8'd1) begin
              r_cnt   <= '0;
              r_state <= RD;
              r_sr    <= r_mem[mem_idx(r_addr)];
            end
          end
          RD: if (w_sck_fall) begin
            // Present the top unit of the fetched byte; after the last unit fetch the next byte.
            r_dio_oe  <= r_wide ? 4'hF : 4'b0010;
            r_dio_out <= r_wide ? r_sr[7:4] : {2'b00, r_sr[7], 1'b0};
            r_sr      <= r_wide ? {r_sr[3:0], 4'h0} : {r_sr[6:0], 1'b0};
            r_cnt     <= r_cnt + 8'd1;
            if (w_unit_last) begin
              r_cnt  <= '0;
              r_addr <= w_addr_next;
              r_sr   <= r_mem[mem_idx(w_addr_next)];
            end
          end
          WR: if (w_sck_rise) begin
            r_sr  <= w_shift;
            r_cnt <= r_cnt + 8'd1;
            if (w_unit_last) begin
              r_cnt  <= '0;
              r_addr <= w_addr_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_dio_out  = r_dio_out;
  assign o_dio_oe   = r_dio_oe;
  assign o_qpi_mode = r_qpi;
  assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_qspi_psram_model.sv
// tb/tb_qspi_psram_model.sv - directed self-checking bench for the serial PSRAM model
module tb_qspi_psram_model;

  logic       i_clk, i_rst_n, i_sck, i_ce_n;
  logic [3:0] i_dio_in;
  logic [3:0] dio_out_a, oe_a, dio_out_b, oe_b;
  logic       qpi_a, err_a, qpi_b, err_b;

  int n_assert = 0;
  int n_fail   = 0;
  int n_err_hi = 0;
  int n_oe_hi  = 0;
  int snap_err, snap_oe;
  logic [7:0] rb;
  logic [7:0] roe;

  qspi_psram_model u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sck(i_sck), .i_ce_n(i_ce_n), .i_dio_in(i_dio_in),
    .o_dio_out(dio_out_a), .o_dio_oe(oe_a), .o_qpi_mode(qpi_a), .o_cmd_err(err_a)
  );

  qspi_psram_model #(.PAGE_BYTES(4)) u_dut_pw (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sck(i_sck), .i_ce_n(i_ce_n), .i_dio_in(i_dio_in),
    .o_dio_out(dio_out_b), .o_dio_oe(oe_b), .o_qpi_mode(qpi_b), .o_cmd_err(err_b)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(negedge i_clk) begin
    if (err_a === 1'b1) n_err_hi++;
    if (oe_a !== 4'h0) n_oe_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] d);
    i_dio_in = d;
    #40 i_sck = 1'b1;
    #40 i_sck = 1'b0;
  endtask

  task automatic ce_start;
    i_ce_n = 1'b0;
    #40;
  endtask

  task automatic ce_stop;
    #40 i_ce_n = 1'b1;
    #80;
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit wide);
    if (wide) begin
      cyc(b[7:4]);
      cyc(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
    end
  endtask

  task automatic tx_addr(input logic [23:0] a, input bit wide);
    tx_byte(a[23:16], wide);
    tx_byte(a[15:8], wide);
    tx_byte(a[7:0], wide);
  endtask

  task automatic dummy(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0);
  endtask

  // Samples each unit just before the rise that follows the device's fall-edge update.
  task automatic rx_byte(input bit wide, input bit pw, output logic [7:0] b, output logic [7:0] oe2);
    logic [3:0] d, oe, o_or, o_and;
    b = '0; o_or = '0; o_and = '1;
    i_dio_in = 4'h0;
    for (int i = 0; i < (wide ? 2 : 8); i++) begin
      #40;
      d  = pw ? dio_out_b : dio_out_a;
      oe = pw ? oe_b : oe_a;
      b  = wide ? {b[3:0], d} : {b[6:0], d[1]};
      o_or  = o_or | oe;
      o_and = o_and & oe;
      i_sck = 1'b1;
      #40 i_sck = 1'b0;
    end
    oe2 = {o_or, o_and};
  endtask

  task automatic rd_check(input string tag, input bit wide, input bit pw,
                          input logic [7:0] exp_b, input logic [3:0] exp_oe);
    rx_byte(wide, pw, rb, roe);
    check({tag, "_data"}, 32'(rb), 32'(exp_b));
    check({tag, "_oe"}, 32'(roe), 32'({exp_oe, exp_oe}));
  endtask

  initial begin
    i_rst_n = 1'b0; i_sck = 1'b0; i_ce_n = 1'b1; i_dio_in = 4'h0;
    #22;
    check("rst_oe", 32'(oe_a), 32'h0);
    check("rst_dout", 32'(dio_out_a), 32'h0);
    check("rst_qpi", 32'(qpi_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);
    i_rst_n = 1'b1;
    #40;

    // Quad write A5 3C at 0x10, then quad read back with 6 dummies.
    ce_start; tx_byte(8'h38, 0); tx_addr(24'h000010, 1); tx_byte(8'hA5, 1); tx_byte(8'h3C, 1); ce_stop;
    ce_start; tx_byte(8'hEB, 0); tx_addr(24'h000010, 1); dummy(5);
    check("quad_oe_dummy", 32'(oe_a), 32'h0);
    dummy(1);
    rd_check("quad_rd0", 1, 0, 8'hA5, 4'hF);
    rd_check("quad_rd1", 1, 0, 8'h3C, 4'hF);
    ce_stop;
    check("quad_oe_after", 32'(oe_a), 32'h0);

    // SPI write 0x81 at 0x20, read back with 03 and 0B.
    ce_start; tx_byte(8'h02, 0); tx_addr(24'h000020, 0); tx_byte(8'h81, 0); ce_stop;
    ce_start; tx_byte(8'h03, 0); tx_addr(24'h000020, 0);
    rd_check("spi_rd", 0, 0, 8'h81, 4'b0010);
    ce_stop;
    ce_start; tx_byte(8'h0B, 0); tx_addr(24'h000020, 0); dummy(8);
    rd_check("spi_fast", 0, 0, 8'h81, 4'b0010);
    ce_stop;

    // QPI entry, 2-nibble command read, exit, and reset-enable/reset exit.
    ce_start; tx_byte(8'h35, 0);
    check("qpi_pending", 32'(qpi_a), 32'h0);
    ce_stop;
    check("qpi_enter", 32'(qpi_a), 32'h1);
    ce_start; tx_byte(8'hEB, 1); tx_addr(24'h000010, 1); dummy(6);
    rd_check("qpi_rd", 1, 0, 8'hA5, 4'hF);
    ce_stop;
    ce_start; tx_byte(8'hF5, 1); ce_stop;
    check("qpi_exit", 32'(qpi_a), 32'h0);
    ce_start; tx_byte(8'h35, 0); ce_stop;
    check("qpi_reenter", 32'(qpi_a), 32'h1);
    ce_start; tx_byte(8'h66, 1); ce_stop;
    check("qpi_rsten", 32'(qpi_a), 32'h1);
    ce_start; tx_byte(8'h99, 1); ce_stop;
    check("qpi_rst", 32'(qpi_a), 32'h0);

    // 4-byte page: write 11 22 33 44 at 0x02 lands at 2,3,0,1.
    ce_start; tx_byte(8'h38, 0); tx_addr(24'h000002, 1);
    tx_byte(8'h11, 1); tx_byte(8'h22, 1); tx_byte(8'h33, 1); tx_byte(8'h44, 1); ce_stop;
    ce_start; tx_byte(8'hEB, 0); tx_addr(24'h000000, 1); dummy(6);
    rd_check("wrap0", 1, 1, 8'h33, 4'hF);
    rd_check("wrap1", 1, 1, 8'h44, 4'hF);
    rd_check("wrap2", 1, 1, 8'h11, 4'hF);
    rd_check("wrap3", 1, 1, 8'h22, 4'hF);
    ce_stop;

    // Abort mid-byte: only the completed byte overwrites.
    ce_start; tx_byte(8'h38, 0); tx_addr(24'h000040, 1); tx_byte(8'h00, 1); tx_byte(8'hEE, 1); ce_stop;
    ce_start; tx_byte(8'h38, 0); tx_addr(24'h000040, 1); tx_byte(8'h77, 1); cyc(4'h8); ce_stop;
    ce_start; tx_byte(8'hEB, 0); tx_addr(24'h000040, 1); dummy(6);
    rd_check("abort0", 1, 0, 8'h77, 4'hF);
    rd_check("abort1", 1, 0, 8'hEE, 4'hF);
    ce_stop;

    // Unsupported command.
    snap_err = n_err_hi; snap_oe = n_oe_hi;
    ce_start; tx_byte(8'h5A, 0); dummy(0);
    for (int i = 0; i < 4; i++) cyc(4'hF);
    check("bad_oe", 32'(oe_a), 32'h0);
    ce_stop;
    check("bad_err_pulse", 32'(n_err_hi - snap_err), 32'd1);
    check("bad_oe_window", 32'(n_oe_hi - snap_oe), 32'd0);
    check("bad_err_low", 32'(err_a), 32'h0);

    // Async reset in the middle of a QPI read; memory must survive.
    ce_start; tx_byte(8'h35, 0); ce_stop;
    ce_start; tx_byte(8'hEB, 1); tx_addr(24'h000010, 1); dummy(6);
    #40;
    check("arst_pre_oe", 32'(oe_a), 32'hF);
    check("arst_pre_qpi", 32'(qpi_a), 32'h1);
    i_rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(oe_a), 32'h0);
    check("arst_qpi", 32'(qpi_a), 32'h0);
    #9;
    i_ce_n = 1'b1; i_sck = 1'b0;
    #20 i_rst_n = 1'b1;
    #40;
    ce_start; tx_byte(8'h03, 0); tx_addr(24'h000010, 0);
    rd_check("arst_mem", 0, 0, 8'hA5, 4'b0010);
    ce_stop;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
